// File: rtl/i2c_master_burst.sv
// Single-master I2C burst controller: START, address+R/W, N data bytes with ACK
// handling, STOP. Open-drain style outputs (1 = pull the line low).
module i2c_master_burst #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 16,
  parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            rw,
  input  logic [6:0]      dev_addr,
  input  logic [NB_W-1:0] nbytes,
  input  logic [7:0]      wr_data,
  output logic            wr_take,
  output logic [7:0]      rd_data,
  output logic            rd_valid,
  output logic            busy,
  output logic            done,
  output logic            nack,
  output logic            scl_oe,
  output logic            sda_oe,
  input  logic            sda_i,
  output logic [3:0]      dbg_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PENULT = DIV_W'(CLK_DIV - 2);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [NB_W-1:0]  NB_MAX     = NB_W'(MAX_BYTES);
  localparam logic [NB_W-1:0]  NB_ONE     = NB_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_MACK, S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic [NB_W-1:0]   cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              samp_q, samp_d;
  logic              sda_s1_q, sda_s2_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              nack_q, nack_d;
  logic              wr_take_q, wr_take_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              scl_oe_q, scl_oe_d;
  logic              sda_oe_q, sda_oe_d;
  logic              bit_end, samp_pt;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    samp_d     = samp_q;
    busy_d     = busy_q;
    nack_d     = nack_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    wr_take_d  = 1'b0;
    rd_valid_d = 1'b0;
    scl_oe_d   = 1'b0;
    sda_oe_d   = 1'b0;
    bit_end    = (div_q == DIV_LAST) && (qtr_q == 2'd3);
    samp_pt    = (div_q == DIV_LAST) && (qtr_q == 2'd2);

    if (state_q != S_IDLE) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          div_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          busy_d  = 1'b1;
          nack_d  = 1'b0;
          rw_d    = rw;
          sh_d    = {dev_addr, rw};
          cnt_d   = (nbytes > NB_MAX) ? NB_MAX : nbytes;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (bit_end) begin
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_ADDR_ACK;
            bit_d   = 3'd0;
          end
        end
      end
      S_ADDR_ACK: begin
        if (samp_pt) samp_d = sda_s2_q;
        if (bit_end) begin
          bit_d = 3'd0;
          if (samp_q) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (cnt_q == '0) begin
            state_d = S_STOP;
          end else if (rw_q) begin
            state_d = S_RDATA;
          end else begin
            state_d   = S_WDATA;
            sh_d      = wr_data;
            wr_take_d = 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (bit_end) begin
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_WACK;
            bit_d   = 3'd0;
          end
        end
      end
      S_WACK: begin
        if (samp_pt) samp_d = sda_s2_q;
        if (bit_end) begin
          cnt_d = cnt_q - NB_ONE;
          if (samp_q) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (cnt_q == NB_ONE) begin
            state_d = S_STOP;
          end else begin
            state_d   = S_WDATA;
            sh_d      = wr_data;
            wr_take_d = 1'b1;
          end
        end
      end
      S_RDATA: begin
        if (samp_pt) sh_d = {sh_q[6:0], sda_s2_q};
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d    = S_MACK;
            bit_d      = 3'd0;
            rd_data_d  = sh_q;
            rd_valid_d = 1'b1;
          end
        end
      end
      S_MACK: begin
        if (bit_end) begin
          cnt_d   = cnt_q - NB_ONE;
          state_d = (cnt_q == NB_ONE) ? S_STOP : S_RDATA;
        end
      end
      S_STOP: begin
        // Leave one cycle early so done/busy land on the final STOP cycle.
        if ((qtr_q == 2'd3) && (div_q == DIV_PENULT)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          div_d   = '0;
          qtr_d   = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line drives are derived from the next-state view so they are registered.
    case (state_d)
      S_START: sda_oe_d = qtr_d[1];
      S_ADDR, S_WDATA: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = ~sh_d[7];
      end
      S_ADDR_ACK, S_WACK, S_RDATA: scl_oe_d = ~qtr_d[1];
      S_MACK: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = (cnt_d > NB_ONE);
      end
      S_STOP: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = (qtr_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      sh_q       <= 8'h00;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      samp_q     <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      wr_take_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      samp_q     <= samp_d;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      wr_take_q  <= wr_take_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign wr_take   = wr_take_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nack      = nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign dbg_state = state_q;

endmodule
